// File: rtl/pci_mon_pkg.sv
// Shared definitions for the PCI protocol monitor: bus-phase encoding,
// check indices and a small phase-decode helper.
package pci_mon_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_ADDR = 3'd1,
    ST_DATA = 3'd2,
    ST_LAST = 3'd3,
    ST_TURN = 3'd4
  } bus_state_e;

  localparam int NUM_CHECKS      = 8;
  localparam int CHK_FRAME_IRDY  = 0;
  localparam int CHK_TRDY_DEVSEL = 1;
  localparam int CHK_IRDY_IDLE   = 2;
  localparam int CHK_DEVSEL_TO   = 3;
  localparam int CHK_CBE_STABLE  = 4;
  localparam int CHK_IRDY_WAIT   = 5;
  localparam int CHK_X_ADDR      = 6;
  localparam int CHK_X_DATA      = 7;

  // DATA and LAST are both data phases for the wait-state and timeout checks.
  function automatic logic is_data_phase(input bus_state_e s);
    return (s == ST_DATA) || (s == ST_LAST);
  endfunction

endpackage

// File: rtl/pci_mon_err_cnt.sv
// Per-check reporting slice: one-cycle pulse, sticky flag and a saturating
// counter. A violation coinciding with clr is kept (sticky=1, count=1).
module pci_mon_err_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset_,
  input  logic             i_clr,
  input  logic             i_viol,
  output logic             o_pulse,
  output logic             o_sticky,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             r_pulse;
  logic             r_sticky;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  // Next count: clear restarts from this cycle's violation, otherwise saturate.
  always_comb begin
    w_cnt_nxt = r_cnt;
    if (i_clr) begin
      w_cnt_nxt = i_viol ? CNT_ONE : CNT_ZERO;
    end else if (i_viol) begin
      w_cnt_nxt = sat_inc(r_cnt);
    end else begin
      w_cnt_nxt = r_cnt;
    end
  end

  // Pulse, sticky and count registers.
  always_ff @(posedge i_clk or negedge i_reset_) begin
    if (!i_reset_) begin
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
      r_cnt    <= CNT_ZERO;
    end else begin
      r_pulse  <= i_viol;
      r_sticky <= i_viol | (r_sticky & ~i_clr);
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign o_pulse  = r_pulse;
  assign o_sticky = r_sticky;
  assign o_cnt    = r_cnt;

endmodule

// File: rtl/pci_protocol_monitor.sv
// Passive PCI bus protocol monitor: phase tracking FSM, per-cycle checks and
// per-check reporting. Define PCI_MON_XCHECK_EN to compile in X-checks 6/7.
module pci_protocol_monitor
  import pci_mon_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int CBE_W          = DATA_W / 8,
  parameter int CNT_W          = 8,
  parameter int DEVSEL_TIMEOUT = 5
) (
  input  logic                    clk,
  input  logic                    reset_,
  input  logic                    FRAME_,
  input  logic                    IRDY_,
  input  logic                    TRDY_,
  input  logic                    DEVSEL_,
  input  logic [CBE_W-1:0]        C_BE_,
  input  logic [DATA_W-1:0]       AD,
  input  logic                    clr,
  output logic [7:0]              err_pulse,
  output logic [7:0]              err_sticky,
  output logic [8*CNT_W-1:0]      err_cnt,
  output logic [CNT_W-1:0]        txn_cnt,
  output logic [2:0]              bus_state
);

  localparam int               TO_W     = $clog2(DEVSEL_TIMEOUT + 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(DEVSEL_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_FIRE  = TO_W'(DEVSEL_TIMEOUT - 1);
  localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
  localparam logic [TO_W-1:0]  TO_ZERO  = {TO_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  bus_state_e              r_state;
  bus_state_e              w_state_nxt;
  logic                    r_prev_frame;
  logic                    r_prev_irdy;
  logic                    r_prev_trdy;
  logic [CBE_W-1:0]        r_prev_cbe;
  logic [TO_W-1:0]         r_to_cnt;
  logic [CNT_W-1:0]        r_txn_cnt;
  logic                    w_xfer;
  logic                    w_in_idle;
  logic                    w_in_addr;
  logic                    w_in_data;
  logic                    w_txn_inc;
  logic [NUM_CHECKS-1:0]   w_viol;

  // Phase state register.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Phase transitions.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: w_state_nxt = FRAME_ ? ST_IDLE : ST_ADDR;
      ST_ADDR: w_state_nxt = ST_DATA;
      ST_DATA: begin
        if (FRAME_) begin
          w_state_nxt = w_xfer ? ST_TURN : ST_LAST;
        end else begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_LAST: w_state_nxt = w_xfer ? ST_TURN : ST_LAST;
      ST_TURN: w_state_nxt = FRAME_ ? ST_IDLE : ST_ADDR;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Phase decodes shared by the checks and the transaction counter.
  always_comb begin
    w_xfer    = !IRDY_ && !TRDY_;
    w_in_idle = (r_state == ST_IDLE);
    w_in_addr = (r_state == ST_ADDR);
    w_in_data = is_data_phase(r_state);
    w_txn_inc = (w_state_nxt == ST_TURN) && (r_state != ST_TURN);
  end

  // Previous-cycle copies; the 1s after reset mask edge checks on release.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_prev_frame <= 1'b1;
      r_prev_irdy  <= 1'b1;
      r_prev_trdy  <= 1'b1;
      r_prev_cbe   <= {CBE_W{1'b0}};
    end else begin
      r_prev_frame <= FRAME_;
      r_prev_irdy  <= IRDY_;
      r_prev_trdy  <= TRDY_;
      r_prev_cbe   <= C_BE_;
    end
  end

  // DEVSEL_ timeout: saturating at the limit is what makes it flag once.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_to_cnt <= TO_ZERO;
    end else if (w_in_addr) begin
      r_to_cnt <= TO_ZERO;
    end else if (w_in_data && DEVSEL_ && (r_to_cnt != TO_LIMIT)) begin
      r_to_cnt <= r_to_cnt + TO_ONE;
    end else begin
      r_to_cnt <= r_to_cnt;
    end
  end

  // Violation conditions for the current sample.
  always_comb begin
    w_viol                  = {NUM_CHECKS{1'b0}};
    w_viol[CHK_FRAME_IRDY]  = !r_prev_frame && FRAME_ && IRDY_;
    w_viol[CHK_TRDY_DEVSEL] = !TRDY_ && DEVSEL_;
    w_viol[CHK_IRDY_IDLE]   = !IRDY_ && w_in_idle;
    w_viol[CHK_DEVSEL_TO]   = w_in_data && DEVSEL_ && (r_to_cnt == TO_FIRE);
    w_viol[CHK_CBE_STABLE]  = w_in_data && !r_prev_irdy && r_prev_trdy &&
                              (C_BE_ != r_prev_cbe);
    w_viol[CHK_IRDY_WAIT]   = w_in_data && !r_prev_irdy && IRDY_ && r_prev_trdy;
`ifdef PCI_MON_XCHECK_EN
    w_viol[CHK_X_ADDR]      = w_in_addr && ($isunknown(AD) || $isunknown(C_BE_));
    w_viol[CHK_X_DATA]      = w_xfer && ($isunknown(AD) || $isunknown(C_BE_));
`else
    w_viol[CHK_X_ADDR]      = 1'b0;
    w_viol[CHK_X_DATA]      = 1'b0;
`endif
  end

`ifndef PCI_MON_XCHECK_EN
  logic w_unused_ad;
  assign w_unused_ad = ^AD;
`endif

  // Completed-transaction counter; an entry to TURN during clr counts as 1.
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      r_txn_cnt <= CNT_ZERO;
    end else if (clr) begin
      r_txn_cnt <= w_txn_inc ? CNT_ONE : CNT_ZERO;
    end else if (w_txn_inc && (r_txn_cnt != CNT_MAX)) begin
      r_txn_cnt <= r_txn_cnt + CNT_ONE;
    end else begin
      r_txn_cnt <= r_txn_cnt;
    end
  end

  for (genvar k = 0; k < NUM_CHECKS; k++) begin : g_chk
    pci_mon_err_cnt #(
      .CNT_W (CNT_W)
    ) u_err (
      .i_clk    (clk),
      .i_reset_ (reset_),
      .i_clr    (clr),
      .i_viol   (w_viol[k]),
      .o_pulse  (err_pulse[k]),
      .o_sticky (err_sticky[k]),
      .o_cnt    (err_cnt[k*CNT_W +: CNT_W])
    );
  end

  assign txn_cnt   = r_txn_cnt;
  assign bus_state = r_state;

endmodule

// File: tb/tb_pci_protocol_monitor.sv
// Self-checking bench for pci_protocol_monitor: directed vector table,
// multi-cycle corner sequences and randomized traffic against a rule model.
module tb_pci_protocol_monitor;

  localparam int DATA_W = 32;
  localparam int CBE_W  = 4;
  localparam int CNT_W  = 8;
  localparam int TO     = 5;
  localparam int CMAX   = (1 << CNT_W) - 1;
`ifdef PCI_MON_XCHECK_EN
  localparam bit XCHK_EN = 1'b1;
`else
  localparam bit XCHK_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              frame, irdy, trdy, devsel, clr;
  logic [CBE_W-1:0]  cbe;
  logic [DATA_W-1:0] ad;
  logic [7:0]        err_pulse, err_sticky;
  logic [8*CNT_W-1:0] err_cnt;
  logic [CNT_W-1:0]  txn_cnt;
  logic [2:0]        bus_state;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pci_protocol_monitor #(
    .DATA_W(DATA_W), .CBE_W(CBE_W), .CNT_W(CNT_W), .DEVSEL_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset_(rst_n), .FRAME_(frame), .IRDY_(irdy), .TRDY_(trdy),
    .DEVSEL_(devsel), .C_BE_(cbe), .AD(ad), .clr(clr),
    .err_pulse(err_pulse), .err_sticky(err_sticky), .err_cnt(err_cnt),
    .txn_cnt(txn_cnt), .bus_state(bus_state)
  );

  // Reference model: spec rules with plain integers.
  int         m_state;
  bit         m_pf, m_pi, m_pt;
  logic [3:0] m_pcbe;
  int         m_to;
  int         m_cnt[8];
  logic [7:0] m_sticky, m_pulse;
  int         m_txn;

  task automatic model_reset();
    m_state = 0; m_pf = 1; m_pi = 1; m_pt = 1; m_pcbe = 4'h0; m_to = 0;
    for (int k = 0; k < 8; k++) m_cnt[k] = 0;
    m_sticky = 8'h00; m_pulse = 8'h00; m_txn = 0;
  endtask

  task automatic model_step(input logic f, input logic i, input logic t, input logic d,
                            input logic [3:0] c, input logic cl, input logic ax);
    logic [7:0] v;
    bit dl, xfer, enter;
    int nxt;
    dl   = (m_state == 2) || (m_state == 3);
    xfer = !i && !t;
    v    = 8'h00;
    v[0] = !m_pf && f && i;
    v[1] = !t && d;
    v[2] = !i && (m_state == 0);
    if (m_state == 1) m_to = 0;
    if (dl && d) begin
      m_to++;
      v[3] = (m_to == TO);
    end
    v[4] = dl && !m_pi && m_pt && (c != m_pcbe);
    v[5] = dl && !m_pi && i && !(!m_pi && !m_pt);
    v[6] = XCHK_EN && (m_state == 1) && ax;
    v[7] = XCHK_EN && xfer && ax;
    nxt = m_state;
    if (m_state == 0)      nxt = f ? 0 : 1;
    else if (m_state == 1) nxt = 2;
    else if (m_state == 2) begin if (f) nxt = xfer ? 4 : 3; end
    else if (m_state == 3) begin if (xfer) nxt = 4; end
    else                   nxt = f ? 0 : 1;
    enter = (nxt == 4) && (m_state != 4);
    for (int k = 0; k < 8; k++) begin
      if (cl) m_cnt[k] = v[k] ? 1 : 0;
      else if (v[k] && m_cnt[k] < CMAX) m_cnt[k]++;
    end
    m_sticky = cl ? v : (m_sticky | v);
    m_pulse  = v;
    if (cl) m_txn = enter ? 1 : 0;
    else if (enter && m_txn < CMAX) m_txn++;
    m_state = nxt; m_pf = f; m_pi = i; m_pt = t; m_pcbe = c;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_model();
    logic [63:0] exp_cnt;
    for (int k = 0; k < 8; k++) exp_cnt[k*8 +: 8] = 8'(m_cnt[k]);
    chk("bus_state",  64'(bus_state),  64'(m_state));
    chk("err_pulse",  64'(err_pulse),  64'(m_pulse));
    chk("err_sticky", 64'(err_sticky), 64'(m_sticky));
    chk("err_cnt",    64'(err_cnt),    exp_cnt);
    chk("txn_cnt",    64'(txn_cnt),    64'(m_txn));
  endtask

  // Drive one bus cycle (called just after a negedge), check after the edge.
  task automatic apply(input logic f, input logic i, input logic t, input logic d,
                       input logic [3:0] c, input logic cl, input logic [31:0] a);
    logic ax;
    frame = f; irdy = i; trdy = t; devsel = d; cbe = c; clr = cl; ad = a;
    ax = $isunknown(a) || $isunknown(c);
    @(posedge clk);
    model_step(f, i, t, d, c, cl, ax);
    @(negedge clk);
    compare_model();
  endtask

  typedef struct {
    logic       f, i, t, d;
    logic [3:0] c;
    logic [2:0] exp_state;
    logic [7:0] exp_pulse;
  } vec_t;

  vec_t tbl[21];
  int   p3;
  logic [3:0] cur_cbe;

  initial begin
    tbl[0]  = '{1'b0,1'b1,1'b1,1'b1,4'h6,3'd1,8'h00};
    tbl[1]  = '{1'b1,1'b0,1'b1,1'b0,4'h0,3'd2,8'h00};
    tbl[2]  = '{1'b1,1'b0,1'b0,1'b0,4'h0,3'd4,8'h00};
    tbl[3]  = '{1'b1,1'b1,1'b1,1'b1,4'h0,3'd0,8'h00};
    tbl[4]  = '{1'b0,1'b1,1'b1,1'b1,4'h7,3'd1,8'h00};
    tbl[5]  = '{1'b0,1'b1,1'b1,1'b0,4'h0,3'd2,8'h00};
    tbl[6]  = '{1'b1,1'b1,1'b1,1'b0,4'h0,3'd3,8'h01};
    tbl[7]  = '{1'b1,1'b0,1'b1,1'b0,4'h0,3'd3,8'h00};
    tbl[8]  = '{1'b1,1'b0,1'b1,1'b0,4'h3,3'd3,8'h10};
    tbl[9]  = '{1'b1,1'b0,1'b0,1'b0,4'h3,3'd4,8'h00};
    tbl[10] = '{1'b1,1'b1,1'b1,1'b1,4'h0,3'd0,8'h00};
    tbl[11] = '{1'b0,1'b1,1'b1,1'b1,4'h2,3'd1,8'h00};
    tbl[12] = '{1'b0,1'b0,1'b1,1'b0,4'h0,3'd2,8'h00};
    tbl[13] = '{1'b0,1'b1,1'b1,1'b0,4'h0,3'd2,8'h20};
    tbl[14] = '{1'b1,1'b0,1'b0,1'b0,4'h0,3'd4,8'h00};
    tbl[15] = '{1'b0,1'b1,1'b1,1'b1,4'h6,3'd1,8'h00};
    tbl[16] = '{1'b1,1'b0,1'b0,1'b1,4'h0,3'd2,8'h02};
    tbl[17] = '{1'b1,1'b0,1'b0,1'b0,4'h0,3'd4,8'h00};
    tbl[18] = '{1'b1,1'b1,1'b1,1'b1,4'h0,3'd0,8'h00};
    tbl[19] = '{1'b1,1'b0,1'b1,1'b1,4'h0,3'd0,8'h04};
    tbl[20] = '{1'b1,1'b1,1'b1,1'b1,4'h0,3'd0,8'h00};

    rst_n = 1'b0; frame = 1'b1; irdy = 1'b1; trdy = 1'b1; devsel = 1'b1;
    cbe = 4'h0; ad = 32'h0; clr = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    compare_model();
    rst_n = 1'b1;

    // Directed table: clean read, check 0, check 4, check 5, checks 1 and 2.
    for (int n = 0; n < 21; n++) begin
      apply(tbl[n].f, tbl[n].i, tbl[n].t, tbl[n].d, tbl[n].c, 1'b0, 32'h1000_0000 + 32'(n));
      chk("tbl_state", 64'(bus_state), 64'(tbl[n].exp_state));
      chk("tbl_pulse", 64'(err_pulse), 64'(tbl[n].exp_pulse));
      if (n == 3) begin
        chk("clean_txn",    64'(txn_cnt),    64'd1);
        chk("clean_sticky", 64'(err_sticky), 64'd0);
      end
    end
    chk("frame_cnt0",    64'(err_cnt[7:0]), 64'd1);
    chk("frame_sticky0", 64'(err_sticky[0]), 64'd1);

    // DEVSEL_ high for 6 data cycles: timeout flags exactly once.
    apply(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 32'h2000_0000);
    p3 = 0;
    for (int n = 0; n < 6; n++) begin
      apply(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 32'h2000_0004);
      p3 += int'(err_pulse[3]);
    end
    chk("to_pulses", 64'(p3), 64'd1);
    apply(1'b1, 1'b0, 1'b1, 1'b0, 4'h6, 1'b0, 32'h0);
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h6, 1'b0, 32'h0);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0);
    chk("to_cnt3", 64'(err_cnt[31:24]), 64'd1);

    // Counter saturation, then clr coinciding with a violation.
    for (int n = 0; n < 300; n++) apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 32'h0);
    chk("sat_cnt1", 64'(err_cnt[15:8]), 64'd255);
    apply(1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b1, 32'h0);
    chk("clr_cnt1",    64'(err_cnt[15:8]),  64'd1);
    chk("clr_sticky1", 64'(err_sticky[1]),  64'd1);
    chk("clr_cnt0",    64'(err_cnt[7:0]),   64'd0);
    chk("clr_txn",     64'(txn_cnt),        64'd0);

    // Reset pulsed mid-DATA; release must not flag checks 0 or 5.
    apply(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 32'h0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 32'h0);
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_model();
    chk("rst_state",  64'(bus_state),  64'd0);
    chk("rst_sticky", 64'(err_sticky), 64'd0);
    #1 rst_n = 1'b1;
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0);
    chk("rst_release_pulse", 64'(err_pulse), 64'd0);

    // AD unknown during ADDR.
    apply(1'b0, 1'b1, 1'b1, 1'b1, 4'h6, 1'b0, 32'h0);
    apply(1'b0, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 32'bx);
    if (!XCHK_EN) chk("x_sticky76", 64'(err_sticky[7:6]), 64'd0);
    else          chk("x_pulse6", 64'(err_pulse[6]), 64'(m_pulse[6]));
    apply(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 32'h0);
    apply(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 1'b0, 32'h0);

    // Randomized traffic against the model.
    cur_cbe = 4'h0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 7) == 0) cur_cbe = 4'($urandom);
      apply(logic'($urandom_range(0, 9) >= 4), logic'($urandom_range(0, 9) >= 6),
            logic'($urandom_range(0, 9) >= 5), logic'($urandom_range(0, 9) >= 7),
            cur_cbe, logic'($urandom_range(0, 63) == 0), $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pci_protocol_monitor.md
# pci_protocol_monitor

Synthesizable, parametrised PCI bus protocol monitor. It is the successor to the simulation-only assertion checkers. It tracks bus phases with a state machine, detects protocol violations cycle by cycle, and reports them as pulses, sticky flags and saturating per-check counters. It sits passively on the PCI bus next to the initiator/target models, or in silicon as a debug observer, and drives nothing onto the bus.

## Interface
Parameters:
- DATA_W, 32, AD bus width
- CBE_W, DATA_W/8, C_BE_ width
- CNT_W, 8, width of every counter
- DEVSEL_TIMEOUT, 5, cycles after the address phase by which DEVSEL_ must assert (≥1)

Ports:
- clk  in  1  bus clock; all state updates on posedge
- reset_  in  1  asynchronous, active-low reset
- FRAME_, IRDY_, TRDY_, DEVSEL_  in  1 each  PCI control signals, active low
- C_BE_  in  CBE_W  command/byte enables
- AD  in  DATA_W  address/data bus
- clr  in  1  synchronous clear of sticky flags and all counters
- err_pulse  out  8  one-cycle violation strobe per check
- err_sticky  out  8  latched violation flags
- err_cnt  out  8*CNT_W  per-check saturating counts; check k occupies bits [k*CNT_W +: CNT_W]
- txn_cnt  out  CNT_W  completed transactions, saturating
- bus_state  out  3  current phase encoding

## Operation
- Inputs are sampled each posedge. Previous-cycle copies (prev_*) of FRAME_, IRDY_, TRDY_, C_BE_ are used for edge and stability detection.
- Transfer = !IRDY_ && !TRDY_.
- State machine:
  - IDLE→ADDR when FRAME_ is low.
  - ADDR→DATA unconditionally.
  - DATA→TURN on transfer with FRAME_ high.
  - DATA→LAST on FRAME_ high without transfer.
  - LAST→TURN on transfer.
  - TURN→ADDR if FRAME_ is low (fast back-to-back), else TURN→IDLE.
  - txn_cnt increments on every entry to TURN.
- Checks (index: condition):
  - 0: FRAME_ rises (prev 0, now 1) while IRDY_ is high.
  - 1: TRDY_ low while DEVSEL_ high.
  - 2: IRDY_ low in IDLE.
  - 3: DEVSEL_ still high DEVSEL_TIMEOUT cycles after ADDR. Timeout counter resets in ADDR and counts each DATA/LAST cycle with DEVSEL_ high. Flags once per transaction.
  - 4: C_BE_ differs from prev_C_BE_ while prev cycle was a wait state (prev IRDY_ low, prev TRDY_ high) in DATA/LAST.
  - 5: IRDY_ rises in DATA/LAST when the previous cycle had no transfer.
  - 6, 7: see Configuration.
- Counters saturate at all-ones and never wrap.
- clr zeroes err_sticky, err_cnt and txn_cnt. A violation in the same cycle as clr wins: sticky=1 and count=1.
- Multiple checks may fire in one cycle; each is handled independently.

## Timing
- Reset values:
  - err_pulse, err_sticky, err_cnt, txn_cnt = 0.
  - bus_state = IDLE (0).
  - prev_FRAME_, prev_IRDY_, prev_TRDY_ = 1.
  - prev_C_BE_ = 0.
- Latency: a violation sampled at edge N drives err_pulse high from edge N until edge N+1. err_sticky and err_cnt update at edge N.
- bus_state is registered and reflects the state entered at the latest edge.
- Reset asserted mid-transaction returns everything to reset values immediately. The first post-reset cycle cannot flag check 0 or 5, because prev values are 1.
- Timeout counter width is $clog2(DEVSEL_TIMEOUT+1) and saturates.

## Configuration
- PCI_MON_XCHECK_EN defined: simulation X-checks are compiled in.
  - Check 6: $isunknown(AD) or $isunknown(C_BE_) in ADDR.
  - Check 7: the same test on any transfer cycle.
- Not defined: bits 6 and 7 of err_pulse/err_sticky/err_cnt are tied to 0, and the block is fully synthesizable.

## Structure
- Package pci_mon_pkg holds:
  - bus-state enum (IDLE=0, ADDR=1, DATA=2, LAST=3, TURN=4);
  - NUM_CHECKS=8;
  - localparam check indices CHK_FRAME_IRDY … CHK_X_DATA.
- Sub-module pci_mon_err_cnt (sticky flag, pulse register and saturating CNT_W counter for one check) is instantiated NUM_CHECKS times in a generate loop.

## Test plan
- Clean single read: FRAME_ low 1 cycle, DEVSEL_ low at cycle 2, transfer at cycle 3 with FRAME_ high → states IDLE,ADDR,DATA,TURN,IDLE; txn_cnt=1; err_sticky=0.
- FRAME_ deasserted with IRDY_ high during DATA → err_pulse[0] for exactly 1 cycle; err_cnt[0]=1; err_sticky[0] stays set.
- DEVSEL_ held high for 6 cycles after ADDR (DEVSEL_TIMEOUT=5) → err_pulse[3] once; err_cnt[3]=1, not 2.
- TRDY_ low with DEVSEL_ high for 300 cycles, CNT_W=8 → err_cnt[1]=255, saturated; clr in the same cycle as a violation → err_cnt[1]=1.
- Wait state with C_BE_ 4'h0→4'h3 → check 4 fires; reset_ pulsed low mid-DATA → all outputs 0, bus_state=IDLE, no spurious check 0/5 on release.
- With PCI_MON_XCHECK_EN defined, AD=X in ADDR → err_pulse[6]. Without the macro, same stimulus → err_sticky[7:6]=0.
